// File: rtl/dclk_tx_if.sv
// Serial transmitter link bundle: upstream item handshake, far-receiver busy
// return and the serial line itself.

`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 4
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 2
`endif

interface dclk_tx_if #(
    parameter int W = `HDR_SZ + `PL_SZ + `ADDR_SZ
) ();
    logic         valid;
    logic [W-1:0] item_in;
    logic         item_read;
    logic         channel_busy;
    logic         serial_out;
    logic         busy;

    // Environment side: upstream producer plus the far receiver's busy line.
    modport master (
        output valid,
        output item_in,
        input  item_read,
        output channel_busy,
        input  serial_out,
        input  busy
    );

    // Transmitter side.
    modport slave (
        input  valid,
        input  item_in,
        output item_read,
        input  channel_busy,
        output serial_out,
        output busy
    );
endinterface

// File: rtl/dclk_tx.sv
// Serial item transmitter: accepts one item, waits for the receiver to be
// clear, sends a 1 head bit then W data bits LSB first, and waits for the
// receiver's busy round trip before taking the next item.

`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 4
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 2
`endif

module dclk_tx #(
    parameter int    routerid = -1,
    parameter string port     = "unknown",
    parameter int    W        = `HDR_SZ + `PL_SZ + `ADDR_SZ
) (
    input logic      rclk,
    input logic      reset,
    dclk_tx_if.slave bus
);
    localparam int CW = $clog2(W);

    if (W < 4) begin : g_bad_width
        $error("dclk_tx router %0d port %s: W must be >= 4", routerid, port);
    end

    typedef enum logic [2:0] {
        StIdle,
        StWaitClear,
        StStart,
        StShift,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic            sync_q;
    logic            busy_s;
    logic [W-1:0]    sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            seen_busy_q, seen_busy_d;
    logic            serial_q, serial_d;
    logic            accept;

    // Two-flop synchronizer for the receiver's asynchronous busy line.
    always_ff @(posedge rclk) begin
        if (reset) begin
            sync_q <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            sync_q <= bus.channel_busy;
            busy_s <= sync_q;
        end
    end

    // State, shift register, bit counter, busy-seen flag and registered line.
    always_ff @(posedge rclk) begin
        if (reset) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            cnt_q       <= '0;
            seen_busy_q <= 1'b0;
            serial_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            seen_busy_q <= seen_busy_d;
            serial_q    <= serial_d;
        end
    end

    // Next state; serial_d is the line value for the state being entered.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        seen_busy_d = seen_busy_q;
        serial_d    = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.valid) begin
                    accept  = 1'b1;
                    sr_d    = bus.item_in;
                    state_d = StWaitClear;
                end
            end
            StWaitClear: begin
                if (!busy_s) begin
                    state_d     = StStart;
                    serial_d    = 1'b1;
                    seen_busy_d = 1'b0;
                end
            end
            StStart: begin
                serial_d = sr_q[0];
                sr_d     = sr_q >> 1;
                cnt_d    = '0;
                state_d  = StShift;
            end
            StShift: begin
                if (busy_s) begin
                    seen_busy_d = 1'b1;
                end
                if (cnt_q == CW'(W - 1)) begin
                    state_d = StDrain;
                end else begin
                    serial_d = sr_q[0];
                    sr_d     = sr_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                // Leave only after the receiver has shown busy and then cleared.
                if (busy_s) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset wins over acceptance, so the pulse is masked while reset is high.
    assign bus.item_read  = accept & ~reset;
    assign bus.serial_out = serial_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_dclk_tx.sv
// Directed bench for dclk_tx with a receiver model on the same clock.
module tb_dclk_tx;
    localparam int W       = 8;
    localparam int CLR_DLY = 5;

    logic rclk  = 1'b0;
    logic reset = 1'b1;

    dclk_tx_if #(.W(W)) bus ();

    dclk_tx #(.routerid(3), .port("east"), .W(W)) dut (
        .rclk  (rclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic         exp_bits[$];
    logic [W-1:0] exp_items[$];
    logic [W-1:0] rx_got[$];

    logic         rx_busy   = 1'b0;
    logic         hold_busy = 1'b0;
    int           rx_st     = 0;
    int           rx_n      = 0;
    int           rx_wait   = 0;
    logic [W-1:0] rx_word   = '0;

    assign bus.channel_busy = rx_busy | hold_busy;

    // Count acceptance pulses mid-cycle.
    always @(negedge rclk) begin
        if (bus.item_read === 1'b1) pulses <= pulses + 1;
    end

    // Receiver: busy on head bit, collect W bits LSB first, clear busy later.
    always @(posedge rclk) begin
        if (reset) begin
            rx_st   <= 0;
            rx_busy <= 1'b0;
        end else begin
            case (rx_st)
                0: begin
                    rx_n <= 0;
                    if (bus.serial_out === 1'b1) begin
                        rx_busy <= 1'b1;
                        rx_st   <= 1;
                    end
                end
                1: begin
                    rx_word <= {bus.serial_out, rx_word[W-1:1]};
                    if (rx_n == W - 1) begin
                        rx_got.push_back({bus.serial_out, rx_word[W-1:1]});
                        rx_wait <= 0;
                        rx_st   <= 2;
                    end else begin
                        rx_n <= rx_n + 1;
                    end
                end
                default: begin
                    if (rx_wait == CLR_DLY - 1) begin
                        rx_busy <= 1'b0;
                        rx_st   <= 0;
                    end else begin
                        rx_wait <= rx_wait + 1;
                    end
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_item(input logic [W-1:0] d);
        exp_items.push_back(d);
        exp_bits.push_back(1'b1);
        for (int i = 0; i < W; i++) exp_bits.push_back(d[i]);
    endtask

    // Called at the negedge where the head bit should be on the line.
    task automatic expect_frame(input string tag);
        for (int i = 0; i <= W; i++) begin
            logic e;
            if (i > 0) @(negedge rclk);
            e = 1'bz;
            if (exp_bits.size() > 0) e = exp_bits.pop_front();
            check($sformatf("%s bit%0d", tag, i), {31'd0, bus.serial_out}, {31'd0, e});
        end
    endtask

    task automatic drain(input string tag);
        logic line_bad  = 1'b0;
        logic timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge rclk);
            if (bus.serial_out !== 1'b0) line_bad = 1'b1;
            if (bus.busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
        check($sformatf("%s line low after frame", tag), {31'd0, line_bad}, 32'd0);
        check($sformatf("%s returns idle", tag), {31'd0, timed_out}, 32'd0);
    endtask

    task automatic check_items(input string tag);
        check($sformatf("%s rx count", tag), rx_got.size(), exp_items.size());
        while (exp_items.size() > 0 && rx_got.size() > 0)
            check($sformatf("%s rx item", tag), {24'd0, rx_got.pop_front()},
                  {24'd0, exp_items.pop_front()});
        exp_items.delete();
        rx_got.delete();
    endtask

    // Accept from idle with receiver clear: head at c2, data c3..c(W+2).
    task automatic run_frame(input logic [W-1:0] d, input string tag);
        int p0;
        @(posedge rclk); #1;
        bus.valid   = 1'b1;
        bus.item_in = d;
        push_item(d);
        p0 = pulses;
        @(negedge rclk);
        check($sformatf("%s c0 item_read", tag), {31'd0, bus.item_read}, 32'd1);
        @(posedge rclk); #1;
        bus.valid   = 1'b0;
        bus.item_in = ~d;
        @(negedge rclk);
        check($sformatf("%s c1 item_read", tag), {31'd0, bus.item_read}, 32'd0);
        check($sformatf("%s c1 line", tag), {31'd0, bus.serial_out}, 32'd0);
        @(negedge rclk);
        expect_frame(tag);
        drain(tag);
        check($sformatf("%s pulses", tag), pulses - p0, 32'd1);
        check_items(tag);
    endtask

    initial begin
        int   n;
        int   p0;
        logic got;
        logic line_bad;

        bus.valid   = 1'b0;
        bus.item_in = '0;
        reset       = 1'b1;

        // Reset outranks a simultaneous acceptance.
        repeat (2) @(posedge rclk);
        #1;
        bus.valid   = 1'b1;
        bus.item_in = 8'h77;
        @(negedge rclk);
        check("reset item_read", {31'd0, bus.item_read}, 32'd0);
        check("reset serial_out", {31'd0, bus.serial_out}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        @(posedge rclk); #1;
        bus.valid = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge rclk);
        check("post-reset idle", {30'd0, bus.busy, bus.serial_out}, 32'd0);

        run_frame(8'hA5, "a5");
        run_frame(8'h00, "zeros");
        run_frame(8'hFF, "ones");

        // Receiver busy before valid: held in WAIT_CLEAR until busy_s falls.
        @(posedge rclk); #1;
        hold_busy = 1'b1;
        repeat (20) @(posedge rclk);
        #1;
        bus.valid   = 1'b1;
        bus.item_in = 8'h3C;
        push_item(8'h3C);
        @(negedge rclk);
        check("held accept", {31'd0, bus.item_read}, 32'd1);
        @(posedge rclk); #1;
        bus.valid = 1'b0;
        line_bad  = 1'b0;
        repeat (5) begin
            @(negedge rclk);
            if (bus.serial_out !== 1'b0) line_bad = 1'b1;
        end
        check("held line low", {31'd0, line_bad}, 32'd0);
        @(posedge rclk); #1;
        hold_busy = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge rclk);
            n++;
            if (bus.serial_out === 1'b1) break;
        end
        // 2 synchronizer flops, START decision, registered line.
        check("held head delay", n, 32'd4);
        expect_frame("held");
        drain("held");
        check_items("held");

        // Two items back to back: second START only after receiver clears.
        p0 = pulses;
        @(posedge rclk); #1;
        bus.valid   = 1'b1;
        bus.item_in = 8'h96;
        push_item(8'h96);
        @(negedge rclk);
        check("b2b first accept", {31'd0, bus.item_read}, 32'd1);
        @(posedge rclk); #1;
        bus.item_in = 8'h4B;
        push_item(8'h4B);
        @(negedge rclk);
        check("b2b c1 item_read", {31'd0, bus.item_read}, 32'd0);
        @(negedge rclk);
        expect_frame("b2b first");
        n = 0;
        while (n < 100 && bus.channel_busy !== 1'b0) begin
            @(negedge rclk);
            n++;
        end
        check("b2b receiver clears", {31'd0, bus.channel_busy}, 32'd0);
        n   = 0;
        got = 1'b0;
        while (n < 50) begin
            @(posedge rclk); #1;
            if (got) bus.valid = 1'b0;
            @(negedge rclk);
            n++;
            if (bus.item_read === 1'b1) got = 1'b1;
            if (bus.serial_out === 1'b1) break;
        end
        // Sync (2) + DRAIN->IDLE + accept + WAIT_CLEAR -> head.
        check("b2b gap", n, 32'd5);
        expect_frame("b2b second");
        bus.valid = 1'b0;
        drain("b2b");
        check("b2b pulses", pulses - p0, 32'd2);
        check_items("b2b");

        // Reset in cycle c5 of a frame discards the item.
        @(posedge rclk); #1;
        bus.valid   = 1'b1;
        bus.item_in = 8'hC3;
        @(negedge rclk);
        check("abort accept", {31'd0, bus.item_read}, 32'd1);
        @(posedge rclk); #1;
        bus.valid = 1'b0;
        repeat (4) @(posedge rclk);
        #1;
        reset = 1'b1;
        @(posedge rclk); #1;
        reset = 1'b0;
        @(negedge rclk);
        check("abort line low", {31'd0, bus.serial_out}, 32'd0);
        check("abort busy low", {31'd0, bus.busy}, 32'd0);
        check("abort nothing received", rx_got.size(), 32'd0);
        exp_bits.delete();
        exp_items.delete();
        rx_got.delete();
        run_frame(8'h3C, "post-abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dclk_tx.md
DCLK_TX -- requirements
Module: dclk_tx

Interface
REQ-001 Parameter routerid, default -1: router identifier, used for debug only.
REQ-002 Parameter port, default "unknown": port name string, used for debug only.
REQ-003 Parameter W, default `HDR_SZ+`PL_SZ+`ADDR_SZ: item width in bits; W SHALL be >= 4.
REQ-004 rclk  input  1  clock; the serial bit clock, which also drives the far receiver's wclk.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 valid  input  1  upstream item available.
REQ-007 item_in  input  W  upstream item, sampled only on acceptance.
REQ-008 item_read  output  1  one-cycle pulse: item_in accepted.
REQ-009 channel_busy  input  1  far receiver busy; asynchronous to rclk.
REQ-010 serial_out  output  1  serial line to the receiver.
REQ-011 busy  output  1  high whenever state != IDLE.

Function
REQ-012 channel_busy SHALL pass through a 2-flop synchronizer (busy_s) before any use.
REQ-013 States: IDLE, WAIT_CLEAR, START, SHIFT, DRAIN, held in a registered state variable.
REQ-014 IDLE & valid: latch item_in into shift register sr, pulse item_read=1 for exactly one cycle, go to WAIT_CLEAR.
REQ-015 item_read SHALL be 0 in every state except the IDLE acceptance cycle; at most one item is held at a time.
REQ-016 WAIT_CLEAR: remain while busy_s=1; go to START when busy_s=0.
REQ-017 START (1 cycle): serial_out=1 (frame head/marker); load bit counter cnt=0; go to SHIFT.
REQ-018 SHIFT: serial_out=sr[0], shift sr right by one, increment cnt; after W cycles (cnt=W-1 sent) go to DRAIN; data order is LSB first.
REQ-019 DRAIN: serial_out=0; remain until busy_s has been observed 1 and then 0 (seen_busy flag), then go to IDLE.
REQ-020 Receiver-side constraint: the frame is W+1 contiguous bits (1, d0..dW-1) and the line is 0 at all other times.
REQ-021 serial_out SHALL be driven from a register, with no combinational path from any input.
REQ-022 Latency: with valid high in IDLE and busy_s=0, the cycles are accept (c0), WAIT_CLEAR (c1), START (c2, serial_out=1), d0..dW-1 on c3..cW+2, and DRAIN from cW+3.
REQ-023 Back-to-back: IDLE SHALL NOT accept a new item in the same cycle it is entered from DRAIN; the minimum gap between frames is therefore the receiver's busy-clear round trip plus 2 cycles.
REQ-024 busy_s rising during WAIT_CLEAR (late-clearing receiver) keeps the block in WAIT_CLEAR with no output change.
REQ-025 valid dropping after acceptance has no effect; item_in changes after acceptance have no effect.
REQ-026 seen_busy SHALL be cleared on entry to START and set in SHIFT or DRAIN whenever busy_s=1.

Reset
REQ-027 On reset, state=IDLE, serial_out=0, item_read=0, busy=0, sr=0, cnt=0, seen_busy=0, and the synchronizer flops are 0.
REQ-028 Reset asserted mid-frame: serial_out=0 from the next cycle and the in-flight item is discarded; the first post-reset frame SHALL still pass through WAIT_CLEAR.
REQ-029 Reset has priority over all other events in the same cycle, including acceptance.

Verification
REQ-030 W=8, busy low, valid=1, item_in=0xA5 -> item_read pulse at c0; serial_out c2..c10 = 1,1,0,1,0,0,1,0,1; 0 thereafter.
REQ-031 channel_busy held 1 for 20 cycles before valid -> item_read at acceptance, no serial_out=1 until 2 cycles after channel_busy falls, then the frame proceeds as in REQ-030.
REQ-032 Two items queued, with the receiver model (rx clocked on the same rclk) raising busy on the head bit and clearing it 5 cycles after the frame ends -> the second START occurs only after busy_s falls, and both items are recovered intact.
REQ-033 Reset pulsed at cycle c5 of a frame -> serial_out=0, busy=0 next cycle; a new item is sent cleanly after reset.
REQ-034 item_in=0x00 and item_in=0xFF -> frames 1,0x8 zeros and 1,1x8 ones; the line returns to 0 after each frame, and item_read pulses exactly once per frame.
